// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD converters and the display driver:
// default widths and the sequential converter's state encoding.
package bin_to_bcd_seq_pkg;

  localparam int DEF_BIN_WIDTH = 32;
  localparam int DEF_NDIGITS   = 10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/bin_to_bcd_seq_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the shift so that doubling it carries correctly into the next digit.
module bcd_digit_adj3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one adjust-and-shift per clock,
// with a start/busy/done handshake and a result register held between conversions.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = DEF_BIN_WIDTH,
  parameter int NDIGITS   = DEF_NDIGITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   bcd
);

  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int BW = 4 * NDIGITS;

  logic [0:0]           state_q,    state_d;
  logic [BIN_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [BW-1:0]        scratch_q,  scratch_d;
  logic [CW-1:0]        count_q,    count_d;
  logic [BW-1:0]        bcd_q,      bcd_d;
  logic                 done_q,     done_d;

  logic [BW-1:0]        adjusted;
  logic [BW-1:0]        shifted;
  logic                 lastStep;

  for (genvar i = 0; i < NDIGITS; i++) begin : gAdj
    bcd_digit_adj3 uAdj (
      .digit_i (scratch_q[4*i +: 4]),
      .digit_o (adjusted[4*i +: 4])
    );
  end

  // The shift register MSB enters digit 0; the top adjusted bit falls off.
  assign shifted  = (adjusted << 1) | BW'(shiftReg_q[BIN_WIDTH-1]);
  assign lastStep = (count_q == CW'(BIN_WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shiftReg_d = bin;
          scratch_d  = '0;
          count_d    = '0;
          state_d    = ST_SHIFT;
        end
      end
      default: begin
        shiftReg_d = shiftReg_q << 1;
        scratch_d  = shifted;
        count_d    = count_q + CW'(1);
        if (lastStep) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shiftReg_q <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: expected BCD values come from a decimal
// model, are queued at each accepted start and checked when done pulses.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bin = '0;
  logic        busy;
  logic        done;
  logic [39:0] bcd;

  int          nChecks = 0;
  int          nFail = 0;
  int          cyc = 0;
  int          doneCount = 0;
  logic        rstAtEdge = 1'b0;
  logic        armed = 1'b0;
  logic [39:0] held = '0;
  logic [39:0] sb[$];

  bin_to_bcd_seq #(.BIN_WIDTH(32), .NDIGITS(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rstAtEdge = rst;
  end

  function automatic logic [39:0] toBcd(input longint unsigned v);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop a result on every done pulse, otherwise the output must hold.
  always @(negedge clk) begin
    if (armed) begin
      if (rstAtEdge) begin
        held = '0;
        checkOutput("resetBcd", 64'(bcd), 64'h0);
        checkOutput("resetDone", 64'(done), 64'h0);
        checkOutput("resetBusy", 64'(busy), 64'h0);
      end else if (done === 1'b1) begin
        doneCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 64'(done), 64'h0);
        end else begin
          held = sb.pop_front();
          checkOutput("result", 64'(bcd), 64'(held));
        end
      end else begin
        checkOutput("bcdHeld", 64'(bcd), 64'(held));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    start = 1'b1;
    bin   = value;
    sb.push_back(toBcd(64'(value)));
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      tick(1);
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    checkOutput("waitDone", 64'(got), 64'h1);
  endtask

  initial begin
    int acceptCyc;
    int lastDone;
    int dc;
    logic [31:0] v;

    armed = 1'b1;
    doReset();
    checkOutput("idleBusy", 64'(busy), 64'h0);

    // Test 1: zero, exact busy length and done position.
    applyStimulus(32'd0);
    checkOutput("busyAtStart", 64'(busy), 64'h1);
    tick(31);
    checkOutput("busyAt31", 64'(busy), 64'h1);
    checkOutput("noDoneAt31", 64'(done), 64'h0);
    tick(1);
    checkOutput("doneAt32", 64'(done), 64'h1);
    checkOutput("busyLowAt32", 64'(busy), 64'h0);
    checkOutput("bcdZero", 64'(bcd), 64'h0);
    tick(1);
    checkOutput("donePulseOne", 64'(done), 64'h0);

    // Test 2: full scale and a mid-range value, output held mid-conversion.
    applyStimulus(32'hFFFF_FFFF);
    tick(16);
    checkOutput("midHoldZero", 64'(bcd), 64'h0);
    waitDone(40);
    checkOutput("maxValue", 64'(bcd), 64'h42_9496_7295);
    tick(1);
    applyStimulus(32'd12345678);
    tick(16);
    checkOutput("midHoldMax", 64'(bcd), 64'h42_9496_7295);
    waitDone(40);
    checkOutput("midValue", 64'(bcd), 64'h00_1234_5678);
    tick(1);

    // Test 3: start while busy is ignored.
    dc = doneCount;
    applyStimulus(32'd99);
    tick(9);
    start = 1'b1;
    bin   = 32'd7;
    tick(1);
    start = 1'b0;
    checkOutput("busyIgnoresStart", 64'(busy), 64'h1);
    waitDone(40);
    checkOutput("ignoredResult", 64'(bcd), 64'h99);
    tick(40);
    checkOutput("singleDone", 64'(doneCount - dc), 64'h1);

    // Test 4: start held high, alternating values, 33-cycle period.
    start = 1'b1;
    bin   = 32'd1000;
    sb.push_back(toBcd(64'd1000));
    tick(1);
    lastDone = 0;
    for (int k = 0; k < 3; k++) begin
      v   = (k % 2 == 0) ? 32'd59 : 32'd1000;
      bin = v;
      sb.push_back(toBcd(64'(v)));
      waitDone(40);
      if (k > 0) checkOutput("donePeriod", 64'(cyc - lastDone), 64'd33);
      lastDone = cyc;
      tick(1);
    end
    start = 1'b0;
    waitDone(40);
    checkOutput("donePeriodLast", 64'(cyc - lastDone), 64'd33);
    checkOutput("alternateLast", 64'(bcd), 64'h59);
    tick(2);

    // Test 5: reset aborts a conversion in flight.
    applyStimulus(32'd555);
    waitDone(40);
    checkOutput("value555", 64'(bcd), 64'h555);
    tick(1);
    start = 1'b1;
    bin   = 32'd8;
    tick(1);
    start = 1'b0;
    tick(14);
    dc  = doneCount;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("abortBcd", 64'(bcd), 64'h0);
    checkOutput("abortBusy", 64'(busy), 64'h0);
    checkOutput("abortDone", 64'(done), 64'h0);
    tick(40);
    checkOutput("noDoneAfterAbort", 64'(doneCount - dc), 64'h0);
    applyStimulus(32'd8);
    acceptCyc = cyc;
    waitDone(40);
    checkOutput("latency", 64'(cyc - acceptCyc), 64'd32);
    checkOutput("value8", 64'(bcd), 64'h8);
    tick(1);

    // Test 6: reset wins over start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    bin   = 32'd77;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rstPriorityBusy", 64'(busy), 64'h0);
    tick(1);
    checkOutput("rstPriorityStill", 64'(busy), 64'h0);
    applyStimulus(32'd77);
    waitDone(40);
    checkOutput("value77", 64'(bcd), 64'h77);
    tick(3);

    checkOutput("scoreboardEmpty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
